// File: rtl/cve2_ex_issue_ctrl_if.sv
// Shared operator types and the request/response channel between an issuer and
// cve2_ex_issue_ctrl.
package cve2_ex_issue_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_MAC
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

endpackage

interface cve2_ex_issue_ctrl_if;
  import cve2_ex_issue_pkg::*;

  // Signal names follow the controller's view of the channel.
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_kind_i;
  alu_op_e     req_alu_op_i;
  md_op_e      req_md_op_i;
  logic [1:0]  req_signed_mode_i;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;
  logic [31:0] req_op_c_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_error_o;

  modport master (
    output req_valid_i, req_kind_i, req_alu_op_i, req_md_op_i, req_signed_mode_i,
    output req_op_a_i, req_op_b_i, req_op_c_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o
  );

  modport slave (
    input  req_valid_i, req_kind_i, req_alu_op_i, req_md_op_i, req_signed_mode_i,
    input  req_op_a_i, req_op_b_i, req_op_c_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o
  );

endinterface

// File: rtl/cve2_ex_issue_ctrl.sv
// Issue controller: latches one ALU/MULT/DIV/MAC request, drives the EX block until it reports a
// result, then holds the response. Define CVE2_EX_ISSUE_TIMEOUT_EN to build in the EXEC watchdog.
module cve2_ex_issue_ctrl
  import cve2_ex_issue_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  cve2_ex_issue_ctrl_if.slave   bus,

  output alu_op_e               alu_operator_o,
  output logic [31:0]           alu_operand_a_o,
  output logic [31:0]           alu_operand_b_o,
  output logic [31:0]           alu_operand_c_o,
  output logic                  alu_instr_first_cycle_o,

  output md_op_e                multdiv_operator_o,
  output logic                  mult_en_o,
  output logic                  div_en_o,
  output logic                  mult_sel_o,
  output logic                  div_sel_o,
  output logic [1:0]            multdiv_signed_mode_o,
  output logic [31:0]           multdiv_operand_a_o,
  output logic [31:0]           multdiv_operand_b_o,

  input  logic [1:0]            imd_val_we_i,
  input  logic [1:0][33:0]      imd_val_d_i,
  output logic [1:0][33:0]      imd_val_q_o,

  input  logic [31:0]           ex_result_i,
  input  logic                  ex_valid_i,

  output logic                  busy_o
);

  localparam logic [1:0] KindMult = 2'b01;
  localparam logic [1:0] KindDiv  = 2'b10;
  localparam logic [1:0] KindMac  = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q;
  alu_op_e         alu_op_q;
  md_op_e          md_op_q;
  logic [1:0]      signed_q;
  logic [31:0]     op_a_q, op_b_q, op_c_q;
  logic            first_q;
  logic            mult_en_q, div_en_q, mult_sel_q, div_sel_q;
  logic [1:0][33:0] imd_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_result_q;

`ifdef CVE2_EX_ISSUE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q;
  logic            rsp_error_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      alu_op_q     <= ALU_ADD;
      md_op_q      <= MD_OP_MULL;
      signed_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_c_q       <= '0;
      first_q      <= 1'b0;
      mult_en_q    <= 1'b0;
      div_en_q     <= 1'b0;
      mult_sel_q   <= 1'b0;
      div_sel_q    <= 1'b0;
      imd_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
`ifdef CVE2_EX_ISSUE_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_error_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid_i) begin
            state_q    <= StExec;
            alu_op_q   <= (bus.req_kind_i == KindMac) ? ALU_MAC : bus.req_alu_op_i;
            md_op_q    <= bus.req_md_op_i;
            signed_q   <= bus.req_signed_mode_i;
            op_a_q     <= bus.req_op_a_i;
            op_b_q     <= bus.req_op_b_i;
            op_c_q     <= bus.req_op_c_i;
            first_q    <= 1'b1;
            mult_en_q  <= (bus.req_kind_i == KindMult);
            mult_sel_q <= (bus.req_kind_i == KindMult);
            div_en_q   <= (bus.req_kind_i == KindDiv);
            div_sel_q  <= (bus.req_kind_i == KindDiv);
`ifdef CVE2_EX_ISSUE_TIMEOUT_EN
            cnt_q      <= CntW'(1);
`endif
          end
        end
        StExec: begin
          first_q <= 1'b0;
          for (int k = 0; k < 2; k++) begin
            if (imd_val_we_i[k]) imd_q[k] <= imd_val_d_i[k];
          end
          // A result arriving in the timeout cycle takes priority over the abort.
          if (ex_valid_i) begin
            state_q      <= StResp;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= ex_result_i;
            mult_en_q    <= 1'b0;
            div_en_q     <= 1'b0;
`ifdef CVE2_EX_ISSUE_TIMEOUT_EN
            rsp_error_q  <= 1'b0;
            cnt_q        <= '0;
          end else if (cnt_q == CntW'(TimeoutCycles)) begin
            state_q      <= StResp;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b1;
            mult_en_q    <= 1'b0;
            div_en_q     <= 1'b0;
            cnt_q        <= '0;
          end else begin
            cnt_q        <= cnt_q + 1'b1;
`endif
          end
        end
        StResp: begin
          if (bus.rsp_ready_i) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            mult_sel_q  <= 1'b0;
            div_sel_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready_o  = (state_q == StIdle);
  assign busy_o           = (state_q != StIdle);
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_result_o = rsp_result_q;
`ifdef CVE2_EX_ISSUE_TIMEOUT_EN
  assign bus.rsp_error_o  = rsp_error_q;
`else
  assign bus.rsp_error_o  = 1'b0;
`endif

  assign alu_operator_o          = alu_op_q;
  assign alu_operand_a_o         = op_a_q;
  assign alu_operand_b_o         = op_b_q;
  assign alu_operand_c_o         = op_c_q;
  assign alu_instr_first_cycle_o = first_q;

  assign multdiv_operator_o    = md_op_q;
  assign mult_en_o             = mult_en_q;
  assign div_en_o              = div_en_q;
  assign mult_sel_o            = mult_sel_q;
  assign div_sel_o             = div_sel_q;
  assign multdiv_signed_mode_o = signed_q;
  assign multdiv_operand_a_o   = op_a_q;
  assign multdiv_operand_b_o   = op_b_q;

  assign imd_val_q_o = imd_q;

endmodule

// File: tb/tb_cve2_ex_issue_ctrl.sv
// Bench for cve2_ex_issue_ctrl: directed cases plus random transactions checked against a
// transaction-level model of latency, selects, intermediate values and responses.
module tb_cve2_ex_issue_ctrl;
  import cve2_ex_issue_pkg::*;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  cve2_ex_issue_ctrl_if bus ();

  alu_op_e          alu_operator;
  logic [31:0]      alu_a, alu_b, alu_c;
  logic             first_cycle;
  md_op_e           md_operator;
  logic             mult_en, div_en, mult_sel, div_sel;
  logic [1:0]       md_signed;
  logic [31:0]      md_a, md_b;
  logic [1:0]       imd_we;
  logic [1:0][33:0] imd_d, imd_q;
  logic [31:0]      ex_result;
  logic             ex_valid;
  logic             busy;

  cve2_ex_issue_ctrl #(.TimeoutCycles(TO)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .bus                    (bus.slave),
    .alu_operator_o         (alu_operator),
    .alu_operand_a_o        (alu_a),
    .alu_operand_b_o        (alu_b),
    .alu_operand_c_o        (alu_c),
    .alu_instr_first_cycle_o(first_cycle),
    .multdiv_operator_o     (md_operator),
    .mult_en_o              (mult_en),
    .div_en_o               (div_en),
    .mult_sel_o             (mult_sel),
    .div_sel_o              (div_sel),
    .multdiv_signed_mode_o  (md_signed),
    .multdiv_operand_a_o    (md_a),
    .multdiv_operand_b_o    (md_b),
    .imd_val_we_i           (imd_we),
    .imd_val_d_i            (imd_d),
    .imd_val_q_o            (imd_q),
    .ex_result_i            (ex_result),
    .ex_valid_i             (ex_valid),
    .busy_o                 (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0][33:0] imd_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_payload();
    bus.req_kind_i        = 2'($urandom_range(0, 3));
    bus.req_alu_op_i      = alu_op_e'($urandom_range(0, 10));
    bus.req_md_op_i       = md_op_e'($urandom_range(0, 3));
    bus.req_signed_mode_i = 2'($urandom_range(0, 3));
    bus.req_op_a_i        = $urandom;
    bus.req_op_b_i        = $urandom;
    bus.req_op_c_i        = $urandom;
  endtask

  // Entered and left at posedge+1 with the controller idle.
  task automatic run_txn(input logic [1:0] kind, input alu_op_e aop, input md_op_e mop,
                         input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input int d, input logic [31:0] res,
                         input logic [1:0] we, input logic [1:0][33:0] wd, input int bp);
    int      exec_n;
    bit      err;
    alu_op_e exp_op;
    logic [31:0] exp_res;
`ifdef CVE2_EX_ISSUE_TIMEOUT_EN
    err    = (d + 1 > int'(TO));
    exec_n = err ? int'(TO) : d + 1;
`else
    err    = 1'b0;
    exec_n = d + 1;
`endif
    exp_res = err ? 32'h0 : res;
    exp_op  = (kind == 2'b11) ? ALU_MAC : aop;

    // Offer cycle: stray imd writes and ex_valid must be ignored while idle.
    bus.req_valid_i = 1'b1;
    bus.req_kind_i = kind; bus.req_alu_op_i = aop; bus.req_md_op_i = mop;
    bus.req_signed_mode_i = sm;
    bus.req_op_a_i = a; bus.req_op_b_i = b; bus.req_op_c_i = c;
    bus.rsp_ready_i = 1'b0;
    imd_we = 2'b11; imd_d = {$urandom, $urandom, $urandom};
    ex_valid = 1'b1; ex_result = $urandom;
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready_o, 1'b1);
    chk("idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    scramble_payload();

    for (int i = 1; i <= exec_n; i++) begin
      ex_valid  = (i == d + 1);
      ex_result = (i == d + 1) ? res : $urandom;
      imd_we    = (i == 1) ? we : 2'b00;
      imd_d     = (i == 1) ? wd : {$urandom, $urandom, $urandom};
      @(negedge clk);
      chk("exec_busy", busy, 1'b1);
      chk("exec_req_ready", bus.req_ready_o, 1'b0);
      chk("exec_rsp_valid", bus.rsp_valid_o, 1'b0);
      chk("exec_first_cycle", first_cycle, (i == 1));
      chk("exec_mult_en", mult_en, (kind == 2'b01));
      chk("exec_div_en", div_en, (kind == 2'b10));
      chk("exec_mult_sel", mult_sel, (kind == 2'b01));
      chk("exec_div_sel", div_sel, (kind == 2'b10));
      chk("exec_alu_op", alu_operator, exp_op);
      chk("exec_md_op", md_operator, mop);
      chk("exec_signed", md_signed, sm);
      chk("exec_alu_a", alu_a, a);
      chk("exec_alu_b", alu_b, b);
      chk("exec_alu_c", alu_c, c);
      chk("exec_md_a", md_a, a);
      chk("exec_md_b", md_b, b);
      if (i == 1) begin
        for (int k = 0; k < 2; k++) if (we[k]) imd_exp[k] = wd[k];
      end
      @(posedge clk); #1;
    end

    // Response phase: stray ex_valid, imd writes and a new request must all be ignored.
    ex_valid = 1'b1; ex_result = $urandom;
    imd_we = 2'b11; imd_d = {$urandom, $urandom, $urandom};
    bus.req_valid_i = 1'b1;
    for (int j = 0; j <= bp; j++) begin
      bus.rsp_ready_i = (j == bp);
      @(negedge clk);
      chk("resp_valid", bus.rsp_valid_o, 1'b1);
      chk("resp_result", bus.rsp_result_o, exp_res);
      chk("resp_error", bus.rsp_error_o, err);
      chk("resp_req_ready", bus.req_ready_o, 1'b0);
      chk("resp_busy", busy, 1'b1);
      chk("resp_mult_en", mult_en, 1'b0);
      chk("resp_div_en", div_en, 1'b0);
      chk("resp_mult_sel", mult_sel, (kind == 2'b01));
      chk("resp_div_sel", div_sel, (kind == 2'b10));
      chk("resp_first_cycle", first_cycle, 1'b0);
      chk("resp_alu_c", alu_c, c);
      chk("resp_imd0", imd_q[0], imd_exp[0]);
      chk("resp_imd1", imd_q[1], imd_exp[1]);
      @(posedge clk); #1;
    end

    bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
    ex_valid = 1'b0; imd_we = 2'b00;
    @(negedge clk);
    chk("after_req_ready", bus.req_ready_o, 1'b1);
    chk("after_busy", busy, 1'b0);
    chk("after_rsp_valid", bus.rsp_valid_o, 1'b0);
    chk("after_mult_sel", mult_sel, 1'b0);
    chk("after_div_sel", div_sel, 1'b0);
    chk("after_alu_a", alu_a, a);
    chk("after_imd0", imd_q[0], imd_exp[0]);
    chk("after_imd1", imd_q[1], imd_exp[1]);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready_o, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid_o, 1'b0);
    chk({tag, "_rsp_error"}, bus.rsp_error_o, 1'b0);
    chk({tag, "_rsp_result"}, bus.rsp_result_o, 32'h0);
    chk({tag, "_mult_en"}, mult_en, 1'b0);
    chk({tag, "_div_en"}, div_en, 1'b0);
    chk({tag, "_mult_sel"}, mult_sel, 1'b0);
    chk({tag, "_div_sel"}, div_sel, 1'b0);
    chk({tag, "_first"}, first_cycle, 1'b0);
    chk({tag, "_alu_a"}, alu_a, 32'h0);
    chk({tag, "_alu_c"}, alu_c, 32'h0);
    chk({tag, "_md_b"}, md_b, 32'h0);
    chk({tag, "_imd0"}, imd_q[0], 34'h0);
    chk({tag, "_imd1"}, imd_q[1], 34'h0);
    chk({tag, "_alu_op"}, alu_operator, ALU_ADD);
    chk({tag, "_md_op"}, md_operator, MD_OP_MULL);
  endtask

  logic [1:0][33:0] wd_div;

  initial begin
    rst_i = 1'b1;
    bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
    scramble_payload();
    imd_we = 2'b00; imd_d = '0; ex_valid = 1'b0; ex_result = '0;
    imd_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;

    // ALU ADD 5+7, result on the first EXEC cycle.
    run_txn(2'b00, ALU_ADD, MD_OP_MULL, 2'b00, 32'd5, 32'd7, 32'd0, 0, 32'd12, 2'b00, '0, 0);
    // DIV with result after 34 EXEC cycles and both intermediate registers written.
    wd_div = {34'h1_0000_0003, 34'h1_0000_0003};
    run_txn(2'b10, ALU_SUB, MD_OP_DIV, 2'b11, 32'd100, 32'd7, 32'd0, 33, 32'd14, 2'b11, wd_div, 0);
    // Backpressure of 5 cycles.
    run_txn(2'b01, ALU_ADD, MD_OP_MULH, 2'b01, 32'h1234, 32'h10, 32'd0, 2, 32'hCAFE, 2'b01,
            {34'h2_AAAA_5555, 34'h0_1111_2222}, 5);
    // MAC 3*4+10.
    run_txn(2'b11, ALU_ADD, MD_OP_MULL, 2'b00, 32'd3, 32'd4, 32'd10, 1, 32'd22, 2'b00, '0, 1);
    // Long wait (aborts in the watchdog build) and a result on EXEC cycle 4.
    run_txn(2'b00, ALU_XOR, MD_OP_MULL, 2'b00, 32'hF0, 32'h0F, 32'd0, 10, 32'hFF, 2'b00, '0, 0);
    run_txn(2'b01, ALU_ADD, MD_OP_MULL, 2'b10, 32'd9, 32'd9, 32'd0, 3, 32'd81, 2'b10,
            {34'h3_0000_0001, 34'h0}, 0);

    // Reset in the middle of a MULT.
    bus.req_valid_i = 1'b1; bus.req_kind_i = 2'b01; bus.req_md_op_i = MD_OP_MULH;
    bus.req_op_a_i = 32'd6; bus.req_op_b_i = 32'd8;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    imd_we = 2'b11; imd_d = {34'h1_2345_6789, 34'h2_3456_789A};
    @(negedge clk);
    chk("mrst_mult_en_before", mult_en, 1'b1);
    @(posedge clk); #1;
    imd_we = 2'b00;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    imd_exp = '0;
    @(negedge clk);
    chk_reset_state("midrst");
    @(posedge clk); #1;

    // Random transactions.
    for (int n = 0; n < 30; n++) begin
      run_txn(2'($urandom_range(0, 3)), alu_op_e'($urandom_range(0, 10)),
              md_op_e'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom,
              $urandom, $urandom_range(0, 6), $urandom, 2'($urandom_range(0, 3)),
              {2'($urandom), $urandom, 2'($urandom), $urandom}, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cve2_ex_issue_ctrl.md
CVE2_EX_ISSUE_CTRL -- requirements
Module: cve2_ex_issue_ctrl

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 64: number of EXEC cycles allowed before abort (watchdog builds only).
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports: clk_i input, 1 bit, clock; rst_i input, 1 bit, synchronous active-high reset.
REQ-003 SHALL have the request handshake ports:
- req_valid_i input 1: request offered.
- req_ready_o output 1: request accepted.
- req_kind_i input 2: 00 ALU, 01 MULT, 10 DIV, 11 MAC.
REQ-004 SHALL have the request payload ports: req_alu_op_i input alu_op_e; req_md_op_i input md_op_e; req_signed_mode_i input 2; req_op_a_i, req_op_b_i, req_op_c_i input 32 each, the operands.
REQ-005 SHALL have these ALU outputs to the EX block: alu_operator_o alu_op_e; alu_operand_a_o, alu_operand_b_o, alu_operand_c_o 32 each; alu_instr_first_cycle_o 1.
REQ-006 SHALL have these multiplier/divider outputs to the EX block: multdiv_operator_o md_op_e; mult_en_o, div_en_o, mult_sel_o, div_sel_o 1 each; multdiv_signed_mode_o 2; multdiv_operand_a_o, multdiv_operand_b_o 32 each.
REQ-007 SHALL have the intermediate-value interface: imd_val_we_i input 2; imd_val_d_i input 2x34; imd_val_q_o output 2x34, the registered intermediate values.
REQ-008 SHALL have the EX result ports: ex_result_i input 32; ex_valid_i input 1.
REQ-009 SHALL have the response ports: rsp_valid_o output 1; rsp_ready_i input 1; rsp_result_o output 32; rsp_error_o output 1 (watchdog abort); busy_o output 1, high when state is not IDLE.

Function
REQ-010 SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-011 SHALL drive req_ready_o = (state==IDLE); when req_valid_i && req_ready_o, SHALL register kind, ops and operands and enter EXEC next cycle.
REQ-012 SHALL hold the registered operands and operators on the EX outputs, constant, from EXEC entry until IDLE.
REQ-013 SHALL drive the select outputs as follows:
- mult_sel_o = kind MULT and state!=IDLE.
- div_sel_o = kind DIV and state!=IDLE.
- mult_en_o, div_en_o: same as the corresponding select, but only in EXEC.
REQ-014 SHALL drive alu_operator_o = ALU_MAC for kind MAC.
REQ-015 SHALL assert alu_instr_first_cycle_o only on the first EXEC cycle of each operation.
REQ-016 SHALL write imd_val_q_o[k] <= imd_val_d_i[k] when imd_val_we_i[k] is set in EXEC, and SHALL ignore imd_val_we_i outside EXEC.
REQ-017 SHALL, on ex_valid_i in EXEC, capture ex_result_i into rsp_result_o with rsp_error_o=0 and enter RESP next cycle; minimum accept-to-rsp_valid_o latency is 2 cycles.
REQ-018 SHALL assert rsp_valid_o only in RESP, with rsp_result_o and rsp_error_o stable until rsp_ready_i; on rsp_valid_o && rsp_ready_i SHALL go to IDLE; no request is accepted in that same cycle (one-cycle bubble).
REQ-019 SHALL ignore ex_valid_i outside EXEC.

Reset
REQ-020 SHALL, on rst_i (including mid-operation), go to IDLE and force these reset values:
- req_ready_o=1.
- rsp_valid_o, rsp_error_o, busy_o, all enables/selects, alu_instr_first_cycle_o = 0.
- rsp_result_o, operands, imd_val_q_o = 0.
- watchdog count = 0.
- alu_operator_o = ALU_ADD; multdiv_operator_o = MD_OP_MULL.

Configuration
REQ-021 SHALL compile the watchdog in only when macro CVE2_EX_ISSUE_TIMEOUT_EN is defined.
REQ-022 SHALL, with CVE2_EX_ISSUE_TIMEOUT_EN defined:
- Count EXEC cycles from 1.
- If TimeoutCycles cycles elapse without ex_valid_i, enter RESP with rsp_result_o=0 and rsp_error_o=1, and drop enables.
- If ex_valid_i arrives in the timeout cycle, ex_valid_i wins and rsp_error_o=0.
REQ-023 SHALL, without CVE2_EX_ISSUE_TIMEOUT_EN: omit the counter, tie rsp_error_o=0, and wait in EXEC indefinitely.

Verification
REQ-024 SHALL cover ALU ADD: a=5, b=7, ex_valid_i=1 with result 12 on the first EXEC cycle -> rsp_valid_o two cycles after accept, rsp_result_o=12, first_cycle pulse exactly 1 cycle.
REQ-025 SHALL cover DIV, ex_valid_i after 34 EXEC cycles, imd_val_we_i=2'b11 with d=34'h1_0000_0003 -> imd_val_q_o holds the value, div_en_o high 34 cycles, result captured.
REQ-026 SHALL cover backpressure: rsp_ready_i low 5 cycles -> rsp_valid_o/rsp_result_o stable, req_ready_o=0; next request is accepted no earlier than the cycle after the handshake.
REQ-027 SHALL cover rst_i asserted in EXEC of a MULT -> the next cycle shows IDLE, mult_en_o=0, imd_val_q_o=0, no rsp_valid_o.
REQ-028 SHALL cover the watchdog build, TimeoutCycles=4, no ex_valid_i -> rsp_error_o=1 and rsp_result_o=0 after 4 EXEC cycles; and ex_valid_i on cycle 4 -> rsp_error_o=0.
REQ-029 SHALL cover MAC: a=3, b=4, c=10, ex_result_i=22 -> alu_operator_o=ALU_MAC, alu_operand_c_o=10, rsp_result_o=22.
